calc_alu_sequencer: RTL
=======================

Name: calc_alu_sequencer

Overview:
- Multi-cycle arithmetic controller for the calculator datapath.
- Owns one shared 16-bit adder plus a 16-bit operand inverter, and sequences them to perform add, subtract, unsigned multiply and unsigned divide.
- Sits between the keypad/operand-entry logic (request side) and the display formatter (response side), with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width; only 16 is supported because the inverter datapath is fixed at 16 bits.
- ITERS, WIDTH, number of EXEC iterations for multiply/divide.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div
- operand_a  in  16  first operand / dividend / multiplicand
- operand_b  in  16  second operand / divisor / multiplier
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- result  out  16  sum, difference, product low half, or quotient
- result_hi  out  16  product high half or remainder; 0 for add/sub
- flag_ovf  out  1  add carry-out, sub borrow (A<B), or mul product > 0xFFFF
- flag_dbz  out  1  divide by zero

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, resp_valid=0, result=0, result_hi=0, flag_ovf=0, flag_dbz=0. req_ready decodes from state, so it is 1 once reset is released.
- Reset mid-operation aborts the operation; the in-flight result is discarded and never presented.
- States:
  - IDLE: wait for a request.
  - EXEC: compute; holds an iteration counter.
  - DONE: present the result.
- Accept: req_valid && req_ready at edge E0 latches the operands and opcode and moves to EXEC. Later input changes are ignored.
- Latency from E0:
  - add/sub: DONE and resp_valid=1 from E1.
  - div-by-zero: DONE from E1.
  - mul/div: DONE from E16.
- DONE holds result, result_hi and flags stable while resp_ready=0.
- resp_valid && resp_ready at an edge moves to IDLE; resp_valid drops and req_ready rises at that same edge.
- No request is accepted outside IDLE.
- Shared datapath: sum = X + (inv ? ~Y : Y) + cin, 17-bit result including carry. Exactly one adder instance is used by all ops.
- add: X=A, Y=B, inv=0, cin=0; flag_ovf=carry.
- sub: X=A, Y=B, inv=1, cin=1; flag_ovf = ~carry (borrow). result wraps modulo 2^16.
- mul (unsigned shift-add):
  - Initialise {c,hi,lo} = {0,0,B}.
  - Each iteration: if lo[0], {c,hi} = hi + A; then shift {c,hi,lo} right by 1.
  - After 16 iterations: result=lo, result_hi=hi, flag_ovf=(hi!=0).
- div (restoring):
  - Initialise rem=0, quot=A.
  - Each iteration: shift {rem,quot} left by 1, keeping the shifted-out bit s. Trial = rem + ~B + 1.
  - If s=1 or carry=1: rem = trial[15:0], quot[0]=1; else quot[0]=0.
  - After 16 iterations: result=quot, result_hi=rem.
- Divide by zero (B=0, op=div): skip the iterations; result=0xFFFF, result_hi=A, flag_dbz=1, flag_ovf=0.
- flag_dbz is 0 for every other op.
- The iteration counter runs 0..15; DONE is entered when counter==15 at the edge. The counter is reset to 0 on accept.
- req_op values outside the map cannot occur (2-bit field is fully decoded).

Decomposition:
- Shared package calc_pkg holds:
  - op codes OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - state encodings ST_IDLE, ST_EXEC, ST_DONE
  - WIDTH=16
  - DBZ_QUOTIENT=16'hFFFF
- One sub-module, calc_addsub_unit: wraps the existing 16-bit inverter and a 16-bit adder with a carry-in.
  - Inputs x, y, inv, cin; output 17-bit sum.
  - Purely combinational; the sequencer instantiates it once.

Test Plan:
1. add A=0x1234, B=0x0FED -> result=0x2221, result_hi=0, flag_ovf=0, resp_valid from E1; add 0xFFFF+0x0002 -> 0x0001, flag_ovf=1.
2. sub 0x0005-0x0007 -> result=0xFFFE, flag_ovf=1; sub 0x8000-0x0001 -> 0x7FFF, flag_ovf=0.
3. mul 0x0123*0x0456 -> result=0xEDC2, result_hi=0x0004, flag_ovf=1, resp_valid from E16; mul 0x00FF*0x0101 -> 0xFFFF, result_hi=0, flag_ovf=0.
4. div 1000/7 -> result=0x008E, result_hi=0x0006; div 0xFFFF/0x0001 -> 0xFFFF rem 0; div 0x1234/0 -> result=0xFFFF, result_hi=0x1234, flag_dbz=1, resp_valid from E1.
5. Backpressure: hold resp_ready=0 for 5 cycles after DONE while pulsing req_valid with new operands -> outputs stable, req_ready=0, no second accept. Raise resp_ready -> IDLE, then the next request is accepted normally.
6. Assert reset during mul iteration 8 -> resp_valid=0 and all outputs 0 immediately; after release req_ready=1, and a following add 0x0001+0x0001 returns 0x0002 from E1.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg
// Shared definitions for the calculator arithmetic sequencer:
//   - operand width and the quotient reported on divide-by-zero
//   - request opcodes (2-bit, fully decoded)
//   - sequencer state encodings
package calc_pkg;

  localparam int WIDTH = 16;
  localparam logic [15:0] DBZ_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } calc_state_e;

endpackage

// File: rtl/calc_addsub_unit.sv
// calc_addsub_unit
// The one shared adder of the calculator datapath: an optional 16-bit
// operand inverter on y followed by a 16-bit adder with carry-in.
// Purely combinational.
//   x    in  16  left operand
//   y    in  16  right operand (inverted when inv=1)
//   inv  in  1   select ~y instead of y
//   cin  in  1   carry-in
//   sum  out 17  {carry, sum}
module calc_addsub_unit
  import calc_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             inv,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH-1:0] y_eff;

  // Inverter plus cin=1 turns the adder into a subtractor (x - y).
  always_comb begin
    y_eff = inv ? ~y : y;
    sum   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, cin};
  end

endmodule

// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer
// Multi-cycle arithmetic controller. Sequences one shared add/sub unit to
// perform add, subtract (1 cycle), unsigned shift-add multiply and unsigned
// restoring divide (16 cycles). Divide by zero finishes in 1 cycle.
//   clk, reset              clock and asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_op                  00 add, 01 sub, 10 mul, 11 div
//   operand_a, operand_b    operands, latched on accept
//   resp_valid/resp_ready   response handshake (valid only in DONE)
//   result, result_hi       low result / quotient, high product / remainder
//   flag_ovf, flag_dbz      carry/borrow/mul-overflow, divide by zero
module calc_alu_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_ovf,
  output logic             flag_dbz
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

  calc_state_e      state_q, state_d;
  calc_op_e         op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // hi/lo form the working pair: {hi,lo} for mul, {rem,quot} for div.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             flag_ovf_q, flag_ovf_d;
  logic             flag_dbz_q, flag_dbz_d;

  logic [WIDTH-1:0] add_x, add_y;
  logic             add_inv, add_cin;
  logic [WIDTH:0]   add_sum;

  // Divide working values: {rem,quot} shifted left by one.
  logic             div_s;
  logic [WIDTH-1:0] rem_sh, quot_sh;
  logic             div_take;
  // Multiply working values: {c,hi} after the conditional add.
  logic             mul_c;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] step_hi, step_lo;

  calc_addsub_unit u_addsub (
    .x   (add_x),
    .y   (add_y),
    .inv (add_inv),
    .cin (add_cin),
    .sum (add_sum)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign flag_ovf   = flag_ovf_q;
  assign flag_dbz   = flag_dbz_q;

  // Operand selection for the shared adder. Kept separate from the
  // next-state logic so the adder output never feeds back into its inputs.
  always_comb begin
    div_s   = hi_q[WIDTH-1];
    rem_sh  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    quot_sh = {lo_q[WIDTH-2:0], 1'b0};
    add_x   = a_q;
    add_y   = b_q;
    add_inv = 1'b0;
    add_cin = 1'b0;
    unique case (op_q)
      OP_ADD: ;
      OP_SUB: begin
        add_inv = 1'b1;
        add_cin = 1'b1;
      end
      OP_MUL: begin
        add_x = hi_q;
        add_y = a_q;
      end
      OP_DIV: begin
        add_x   = rem_sh;
        add_y   = b_q;
        add_inv = 1'b1;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  // One iteration step of mul/div computed from the adder result.
  always_comb begin
    {mul_c, mul_hi} = lo_q[0] ? add_sum : {1'b0, hi_q};
    div_take        = div_s | add_sum[WIDTH];
    if (op_q == OP_MUL) begin
      step_hi = {mul_c, mul_hi[WIDTH-1:1]};
      step_lo = {mul_hi[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_take ? add_sum[WIDTH-1:0] : rem_sh;
      step_lo = {quot_sh[WIDTH-1:1], div_take};
    end
  end

  // Next-state and result capture. Results are only written on entry to
  // DONE, so they stay stable while the consumer back-pressures.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flag_ovf_d  = flag_ovf_q;
    flag_dbz_d  = flag_dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = calc_op_e'(req_op);
          a_d     = operand_a;
          b_d     = operand_b;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = (calc_op_e'(req_op) == OP_MUL) ? operand_b : operand_a;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          result_d    = add_sum[WIDTH-1:0];
          result_hi_d = '0;
          flag_ovf_d  = (op_q == OP_ADD) ? add_sum[WIDTH] : ~add_sum[WIDTH];
          flag_dbz_d  = 1'b0;
          state_d     = ST_DONE;
        end else if (op_q == OP_DIV && b_q == '0) begin
          result_d    = DBZ_QUOTIENT;
          result_hi_d = a_q;
          flag_ovf_d  = 1'b0;
          flag_dbz_d  = 1'b1;
          state_d     = ST_DONE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            result_d    = step_lo;
            result_hi_d = step_hi;
            flag_ovf_d  = (op_q == OP_MUL) && (step_hi != '0);
            flag_dbz_d  = 1'b0;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flag_ovf_q  <= 1'b0;
      flag_dbz_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flag_ovf_q  <= flag_ovf_d;
      flag_dbz_q  <= flag_dbz_d;
    end
  end

endmodule
